// File: rtl/muldiv8_pkg.sv
// Shared definitions for the operand-load sequencer: default sizes and the
// sequencer state encoding.
package muldiv8_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int SLOTS_DEF = 4;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    GATE,
    HOLD,
    CLEAR
  } state_t;

  // Keeps the slot select at least one bit wide for a single-slot bank.
  function automatic int slot_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/opload_seq.sv
// Write sequencer for a bank of level-sensitive latch words: sets up D, pulses
// one GATE for a single clock, holds D, and runs bank-wide clears via RESET_B.
module opload_seq
  import muldiv8_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SLOTS = SLOTS_DEF,
  localparam int SLOT_W = slot_bits(SLOTS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  input  logic [SLOT_W-1:0] in_slot,
  input  logic              clr,
  output logic [WIDTH-1:0]  latch_d,
  output logic [SLOTS-1:0]  latch_gate,
  output logic              latch_reset_b,
  output logic              all_loaded,
  output logic              busy
);

  state_t              state_reg, state_next;
  logic [SLOT_W-1:0]   slot_reg, slot_next;
  logic                slot_ok_reg, slot_ok_next;
  logic [WIDTH-1:0]    d_reg, d_next;
  logic [SLOTS-1:0]    gate_reg, gate_next;
  logic [SLOTS-1:0]    mask_reg, mask_next;
  logic                pend_reg, pend_next;
  logic                all_loaded_reg;
  logic                reset_b_reg, reset_b_next;
  logic                busy_reg, busy_next;
  logic                in_slot_ok;

  assign in_slot_ok = ({1'b0, in_slot} < (SLOT_W + 1)'(SLOTS));
  assign in_ready   = (state_reg == IDLE) && !clr;

  always_comb begin
    state_next   = state_reg;
    slot_next    = slot_reg;
    slot_ok_next = slot_ok_reg;
    d_next       = d_reg;
    gate_next    = gate_reg;
    mask_next    = mask_reg;
    pend_next    = pend_reg;
    case (state_reg)
      IDLE: begin
        if (clr) begin
          state_next = CLEAR;
        end else if (in_valid) begin
          state_next   = SETUP;
          d_next       = in_data;
          slot_next    = in_slot;
          slot_ok_next = in_slot_ok;
        end
      end
      SETUP: begin
        // Out-of-range slots still walk every state, just without a gate.
        gate_next  = slot_ok_reg ? (SLOTS'(1) << slot_reg) : '0;
        pend_next  = pend_reg | clr;
        state_next = GATE;
      end
      GATE: begin
        gate_next  = '0;
        pend_next  = pend_reg | clr;
        state_next = HOLD;
      end
      HOLD: begin
        if (slot_ok_reg) mask_next[slot_reg] = 1'b1;
        if (pend_reg || clr) begin
          state_next = CLEAR;
          pend_next  = 1'b0;
        end else begin
          state_next = IDLE;
        end
      end
      CLEAR: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        gate_next  = '0;
      end
    endcase
    // The clear wipes the mask on entry, overriding a bit set by the final HOLD.
    if (state_next == CLEAR) mask_next = '0;
    reset_b_next = (state_next != CLEAR);
    busy_next    = (state_next != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      slot_reg       <= '0;
      slot_ok_reg    <= 1'b0;
      d_reg          <= '0;
      gate_reg       <= '0;
      mask_reg       <= '0;
      pend_reg       <= 1'b0;
      all_loaded_reg <= 1'b0;
      reset_b_reg    <= 1'b0;
      busy_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      slot_reg       <= slot_next;
      slot_ok_reg    <= slot_ok_next;
      d_reg          <= d_next;
      gate_reg       <= gate_next;
      mask_reg       <= mask_next;
      pend_reg       <= pend_next;
      all_loaded_reg <= &mask_reg;
      reset_b_reg    <= reset_b_next;
      busy_reg       <= busy_next;
    end
  end

  assign latch_d       = d_reg;
  assign latch_gate    = gate_reg;
  assign latch_reset_b = reset_b_reg;
  assign all_loaded    = all_loaded_reg;
  assign busy          = busy_reg;

endmodule

// File: doc/opload_seq.md
OPLOAD_SEQ -- requirements
Module: opload_seq

Interface
REQ-001 The parameter WIDTH SHALL default to 8 and sets the operand byte width.
REQ-002 The parameter SLOTS SHALL default to 4 and sets the number of latch words in the downstream bank.
REQ-003 The port clk SHALL be an input, 1 bit wide, and is the single clock.
REQ-004 The port rst_n SHALL be an input, 1 bit wide, and is the asynchronous active-low reset.
REQ-005 The port in_valid SHALL be an input, 1 bit wide, and flags a write request.
REQ-006 The port in_ready SHALL be an output, 1 bit wide, and shows the sequencer can accept a write.
REQ-007 The port in_data SHALL be an input, WIDTH bits wide, and carries the operand byte.
REQ-008 The port in_slot SHALL be an input, clog2(SLOTS) bits wide, and selects the target latch word.
REQ-009 The port clr SHALL be an input, 1 bit wide, and requests a clear of the whole latch bank.
REQ-010 The port latch_d SHALL be an output, WIDTH bits wide, and is the shared data to the latch D pins.
REQ-011 The port latch_gate SHALL be an output, SLOTS bits wide, and carries the per-word GATE enables (active-high).
REQ-012 The port latch_reset_b SHALL be an output, 1 bit wide, and is the bank-wide RESET_B (active-low).
REQ-013 The port all_loaded SHALL be an output, 1 bit wide, and is high when every slot has been written since the last clear.
REQ-014 The port busy SHALL be an output, 1 bit wide, and is high whenever the state is not IDLE.

Function
REQ-015 The state machine SHALL have exactly these states: IDLE, SETUP, GATE, HOLD, CLEAR.
REQ-016 in_ready SHALL equal (state==IDLE) && !clr; it is the only combinational output.
REQ-017 An accept (in_valid && in_ready at edge E0) SHALL load latch_d <= in_data and the slot register, and move the state to SETUP.
REQ-018 In SETUP, the next edge (E1) SHALL set latch_gate[slot]=1 and move the state to GATE.
REQ-019 In GATE, edge E2 SHALL clear latch_gate to 0 and move the state to HOLD; latch_d stays constant from E0 through E3.
REQ-020 In HOLD, edge E3 SHALL set loaded_mask[slot]=1 and return the state to IDLE; in_ready is high again from E3, so the rate is at most one write per 4 cycles.
REQ-021 latch_gate SHALL come directly from flops, be zero or one-hot at all times, and stay high for exactly one clock per write.
REQ-022 A write with in_slot >= SLOTS SHALL run through all states with latch_gate held at 0 and loaded_mask unchanged.
REQ-023 clr sampled in IDLE SHALL enter CLEAR: latch_reset_b=0 for exactly one cycle, loaded_mask cleared, latch_d unchanged, then return to IDLE.
REQ-024 clr asserted during SETUP/GATE/HOLD SHALL be captured in a pending flag, and CLEAR SHALL follow HOLD directly, without passing through IDLE.
REQ-025 If clr and in_valid are both high in IDLE, clr SHALL win, and the write SHALL NOT be accepted that cycle.
REQ-026 A rewrite of an already-loaded slot SHALL be allowed and SHALL leave its mask bit set.
REQ-027 all_loaded SHALL be a registered &loaded_mask; it updates at the edge after the mask changes.
REQ-028 latch_reset_b and latch_gate SHALL never both be active in the same cycle.

Reset
REQ-029 When rst_n is low, the block SHALL asynchronously force: state=IDLE, latch_gate=0, latch_d=0, loaded_mask=0, pending clear=0, all_loaded=0, busy=0, latch_reset_b=0.
REQ-030 latch_reset_b SHALL go to 1 at the first clk edge after rst_n is released.
REQ-031 A reset during SETUP/GATE/HOLD SHALL abandon the write, drop latch_gate immediately, and leave the mask bit unset.

Structure
REQ-032 The state enum and the SLOTS/WIDTH defaults SHALL live in the shared package muldiv8_pkg.
REQ-033 The design SHALL have no sub-module; the sg13g2_dlhrq latch bank is instantiated by the parent, one cell per bit, with GATE=latch_gate[s], D=latch_d[b] and RESET_B=latch_reset_b.

Verification
REQ-034 Scenario: after reset release, write slot 2 with 0xA5 -> latch_gate==4'b0100 for exactly cycle E1-E2, latch_d==0xA5 over E0-E3, in_ready back high at E3.
REQ-035 Scenario: write slots 0..3 back-to-back with in_valid held high -> writes accepted every 4 cycles, all_loaded rises one edge after the fourth HOLD.
REQ-036 Scenario: clr pulse during GATE of a slot-1 write -> the write completes, CLEAR follows HOLD with latch_reset_b low for 1 cycle, mask==0, all_loaded==0.
REQ-037 Scenario: clr and in_valid high together in IDLE -> in_ready==0, no gate pulse, CLEAR is entered.
REQ-038 Scenario: rst_n low in the middle of GATE -> latch_gate==0 and latch_reset_b==0 immediately, mask bit not set after release.
REQ-039 Scenario: a bench model of the latch bank SHALL match the written bytes at every cycle, and an assertion SHALL check onehot0(latch_gate) throughout.
